// File: rtl/fifo_watermark_pkg.sv
// Shared definitions for fifo_watermark: constant helpers for sizing and
// parameter checking, plus the registered status-flag bundle.
package fifo_watermark_pkg;

    // Registered occupancy flags, all derived from the same word count.
    typedef struct packed {
        logic not_empty;
        logic full;
        logic almost_full;
        logic almost_empty;
    } status_t;

    // Flags of an empty FIFO with in-range thresholds.
    localparam status_t STATUS_RESET = '{
        not_empty:    1'b0,
        full:         1'b0,
        almost_full:  1'b0,
        almost_empty: 1'b1
    };

    // Ceiling log2 usable in parameter and port declarations.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Flag set for a given occupancy.
    function automatic status_t status_of(input int count, input int depth,
                                          input int afull, input int aempty);
        status_t s;
        s.not_empty    = (count != 0);
        s.full         = (count == depth);
        s.almost_full  = (count >= afull);
        s.almost_empty = (count <= aempty);
        return s;
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read with read
// enable. Read-during-write to the same address returns the old word.
module fifo_dp_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array write port.
    // NOTE: the array has no reset so it maps onto RAM macros; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register, holds its value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_watermark.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// watermarks and sticky overflow/underflow flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise a read
// pops into a registered DOUT that is valid for one cycle.
module fifo_watermark
    import fifo_watermark_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 32,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      DIN,
    input  logic                  WE,
    input  logic                  RE,
    output logic [WIDTH-1:0]      DOUT,
    output logic                  DOUT_VALID,
    output logic                  NOT_EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [clog2(DEPTH):0] COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    if (WIDTH < 1) begin : g_bad_width
        $error("fifo_watermark: WIDTH must be >= 1");
    end
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("fifo_watermark: DEPTH must be a power of two >= 4");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_watermark: AFULL_THRESH must lie in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_watermark: AEMPTY_THRESH must lie in 0..DEPTH-1");
    end

    // Pointers carry one extra MSB so wr_ptr - rd_ptr spans 0..DEPTH.
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [PTR_W-1:0]  count_q, count_next;
    status_t           status_q, status_next;
    logic              overflow_q, underflow_q;
    logic              rd_ok, wr_ok;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic [WIDTH-1:0]  ram_rdata;

    // Accept decisions and the post-edge occupancy they produce.
    // NOTE: every always_comb output is assigned on every path so no latch is inferred.
    always_comb begin
        rd_ok       = RE & status_q.not_empty;
        wr_ok       = WE & (~status_q.full | rd_ok);
        wr_ptr_next = wr_ptr + PTR_W'(wr_ok);
        rd_ptr_next = rd_ptr + PTR_W'(rd_ok);
        count_next  = wr_ptr_next - rd_ptr_next;
        status_next = status_of(int'(count_next), DEPTH, AFULL_THRESH, AEMPTY_THRESH);
    end

    // Pointers, count, flags and sticky error bits.
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            status_q    <= STATUS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            count_q  <= count_next;
            status_q <= status_next;
            if (WE && !wr_ok) begin
                overflow_q <= 1'b1;
            end
            if (RE && !rd_ok) begin
                underflow_q <= 1'b1;
            end
        end
    end

    fifo_dp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (CLK),
        .rst  (RESET),
        .we   (wr_ok),
        .waddr(wr_ptr[ADDR_W-1:0]),
        .wdata(DIN),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

`ifdef FIFO_FWFT_EN
    // The head word always sits on DOUT. It comes either from a bypass
    // register (word written while the FIFO was empty or becoming empty)
    // or from the RAM read of the word following the one being popped.
    logic [ADDR_W-1:0] next_addr;
    logic              bypass_load;
    logic              sel_ram;
    logic [WIDTH-1:0]  bypass_q;

    // Choose where the next head word comes from.
    always_comb begin
        next_addr   = rd_ptr[ADDR_W-1:0] + ADDR_W'(1);
        ram_raddr   = next_addr;
        ram_re      = rd_ok & (count_q >= PTR_W'(2));
        bypass_load = wr_ok & ((count_q == '0) | (rd_ok & (count_q == PTR_W'(1))));
    end

    // Head-word source select and bypass capture.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sel_ram  <= 1'b0;
            bypass_q <= '0;
        end else if (bypass_load) begin
            sel_ram  <= 1'b0;
            bypass_q <= DIN;
        end else if (ram_re) begin
            sel_ram  <= 1'b1;
        end
    end

    assign DOUT       = sel_ram ? ram_rdata : bypass_q;
    assign DOUT_VALID = status_q.not_empty;
`else
    logic dout_valid_q;

    // Pop reads the head word straight into the RAM read register.
    always_comb begin
        ram_re    = rd_ok;
        ram_raddr = rd_ptr[ADDR_W-1:0];
    end

    // DOUT_VALID marks the single cycle after an accepted read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_ok;
        end
    end

    assign DOUT       = ram_rdata;
    assign DOUT_VALID = dout_valid_q;
`endif

    assign COUNT        = count_q;
    assign NOT_EMPTY    = status_q.not_empty;
    assign FULL         = status_q.full;
    assign ALMOST_FULL  = status_q.almost_full;
    assign ALMOST_EMPTY = status_q.almost_empty;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_fifo_watermark.sv
// Self-checking bench for fifo_watermark (WIDTH=8, DEPTH=16, AFULL=12,
// AEMPTY=2). Works with and without FIFO_FWFT_EN; the reference model is a
// queue of words plus sticky flags.
module tb_fifo_watermark;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 12;
    localparam int AEMPTY = 2;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic [WIDTH-1:0] DIN = '0;
    logic             WE = 1'b0;
    logic             RE = 1'b0;
    logic [WIDTH-1:0] DOUT;
    logic             DOUT_VALID, NOT_EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY;
    logic             OVERFLOW, UNDERFLOW;
    logic [4:0]       COUNT;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [7:0] q[$];
    bit         m_ovf, m_unf, m_valid;
    logic [7:0] m_dout;

    fifo_watermark #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
    ) dut (
        .CLK(CLK), .RESET(RESET), .DIN(DIN), .WE(WE), .RE(RE),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .NOT_EMPTY(NOT_EMPTY), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT),
        .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] dut_vec();
        return {COUNT, NOT_EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY,
                OVERFLOW, UNDERFLOW, DOUT_VALID, DOUT};
    endfunction

    function automatic logic [19:0] exp_vec();
        int n;
        n = q.size();
        return {5'(n), n != 0, n == DEPTH, n >= AFULL, n <= AEMPTY,
                m_ovf, m_unf, m_valid, m_dout};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_dout  = 8'h00;
    endtask

    // One clock: drive, update the model at the edge, sample 1 time unit later.
    // 'word' is the word the DUT handed out on an accepted read.
    task automatic step(input logic we, input logic re, input logic [7:0] d,
                        output logic [7:0] word);
        bit rd_ok, wr_ok;
        logic [7:0] popped;
`ifdef FIFO_FWFT_EN
        logic [7:0] head_before;
`endif
        WE = we; RE = re; DIN = d;
`ifdef FIFO_FWFT_EN
        head_before = DOUT;
`endif
        @(posedge CLK);
        rd_ok = re && (q.size() != 0);
        wr_ok = we && ((q.size() < DEPTH) || rd_ok);
        if (we && !wr_ok) m_ovf = 1'b1;
        if (re && !rd_ok) m_unf = 1'b1;
        popped = 8'h00;
        if (rd_ok) popped = q.pop_front();
        if (wr_ok) q.push_back(d);
`ifdef FIFO_FWFT_EN
        m_valid = (q.size() != 0);
        if (m_valid) m_dout = q[0];
`else
        m_valid = rd_ok;
        if (rd_ok) m_dout = popped;
`endif
        #1;
        WE = 1'b0; RE = 1'b0;
`ifdef FIFO_FWFT_EN
        word = head_before;
`else
        word = DOUT;
`endif
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] w;
        logic [19:0] rst_vec;
        rst_vec = {5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        RESET = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        n_checks++;
        if (dut_vec() !== rst_vec) $display("FAIL reset_state: got %h expected %h", dut_vec(), rst_vec);
        else n_pass++;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), w);
        n_checks++;
        if (COUNT !== 5'd7) $display("FAIL reset_prefill_count: got %0d expected 7", COUNT);
        else n_pass++;
        #2;
        RESET = 1'b1;
        #1;
        n_checks++;
        if ({COUNT, NOT_EMPTY, ALMOST_EMPTY} !== {5'd0, 1'b0, 1'b1})
            $display("FAIL reset_async: got count=%0d ne=%b ae=%b expected 0 0 1", COUNT, NOT_EMPTY, ALMOST_EMPTY);
        else n_pass++;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), w);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h00, w);
            n_checks++;
            if (w !== 8'(8'hC0 + i)) $display("FAIL reset_new_data: got %h expected %h", w, 8'(8'hC0 + i));
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL reset_status: got %h expected %h", dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_fill();
        logic [7:0] w;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i), w);
            n_checks++;
            if ({ALMOST_EMPTY, ALMOST_FULL, FULL} !== {i < 2, i >= 11, i == 15})
                $display("FAIL fill_flags_%0d: got ae=%b af=%b full=%b", i, ALMOST_EMPTY, ALMOST_FULL, FULL);
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL fill_status: got %h expected %h", dut_vec(), exp_vec());
            else n_pass++;
        end
        step(1'b1, 1'b0, 8'hAA, w);
        n_checks++;
        if ({COUNT, OVERFLOW} !== {5'd16, 1'b1})
            $display("FAIL fill_overflow: got count=%0d ovf=%b expected 16 1", COUNT, OVERFLOW);
        else n_pass++;
    endtask

    task automatic test_drain();
        logic [7:0] w;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, w);
            n_checks++;
            if (w !== 8'(i)) $display("FAIL drain_data_%0d: got %h expected %h", i, w, 8'(i));
            else n_pass++;
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL drain_status: got %h expected %h", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (NOT_EMPTY !== 1'b0) $display("FAIL drain_empty: got ne=%b expected 0", NOT_EMPTY);
        else n_pass++;
        step(1'b0, 1'b1, 8'h00, w);
        n_checks++;
        if ({COUNT, UNDERFLOW} !== {5'd0, 1'b1})
            $display("FAIL drain_underflow: got count=%0d unf=%b expected 0 1", COUNT, UNDERFLOW);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [7:0] w;
        apply_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), w);
        step(1'b1, 1'b1, 8'h55, w);
        n_checks++;
        if ({COUNT, OVERFLOW, w} !== {5'd16, 1'b0, 8'h00})
            $display("FAIL simul_full: got count=%0d ovf=%b word=%h expected 16 0 00", COUNT, OVERFLOW, w);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, w);
            n_checks++;
            if (w !== ((i < 15) ? 8'(i + 1) : 8'h55))
                $display("FAIL simul_drain_%0d: got %h expected %h", i, w, (i < 15) ? 8'(i + 1) : 8'h55);
            else n_pass++;
        end
        step(1'b1, 1'b1, 8'h33, w);
        n_checks++;
        if ({COUNT, UNDERFLOW} !== {5'd1, 1'b1})
            $display("FAIL simul_empty: got count=%0d unf=%b expected 1 1", COUNT, UNDERFLOW);
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL simul_status: got %h expected %h", dut_vec(), exp_vec());
        else n_pass++;
        step(1'b0, 1'b1, 8'h00, w);
        n_checks++;
        if (w !== 8'h33) $display("FAIL simul_read33: got %h expected 33", w);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] w;
        int sent, got, cyc;
        bit we, re;
        apply_reset();
        sent = 0; got = 0; cyc = 0;
        while (got < 256 && cyc < 4000) begin
            re = (cyc % 4 != 3) && (q.size() != 0) && ($urandom_range(0, 5) != 0);
            we = (sent < 256) && ((q.size() < DEPTH) || re) && ($urandom_range(0, 7) != 0);
            step(we, re, 8'(sent), w);
            if (we) sent++;
            if (re) begin
                n_checks++;
                if (w !== 8'(got)) $display("FAIL wrap_data_%0d: got %h expected %h", got, w, 8'(got));
                else n_pass++;
                got++;
            end
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL wrap_status_cyc%0d: got %h expected %h", cyc, dut_vec(), exp_vec());
            else n_pass++;
            cyc++;
        end
        n_checks++;
        if (got !== 256) $display("FAIL wrap_timeout: got %0d words expected 256", got);
        else n_pass++;
        n_checks++;
        if ({OVERFLOW, UNDERFLOW} !== 2'b00) $display("FAIL wrap_sticky: got ovf=%b unf=%b expected 0 0", OVERFLOW, UNDERFLOW);
        else n_pass++;
    endtask

    task automatic test_head();
        logic [7:0] w;
        apply_reset();
        step(1'b1, 1'b0, 8'h7E, w);
        step(1'b0, 1'b0, 8'h00, w);
        n_checks++;
`ifdef FIFO_FWFT_EN
        if ({COUNT, DOUT_VALID, DOUT} !== {5'd1, 1'b1, 8'h7E})
            $display("FAIL head_present: got count=%0d valid=%b dout=%h expected 1 1 7e", COUNT, DOUT_VALID, DOUT);
`else
        if ({COUNT, DOUT_VALID, DOUT} !== {5'd1, 1'b0, 8'h00})
            $display("FAIL head_present: got count=%0d valid=%b dout=%h expected 1 0 00", COUNT, DOUT_VALID, DOUT);
`endif
        else n_pass++;
        step(1'b0, 1'b1, 8'h00, w);
        n_checks++;
        if (w !== 8'h7E) $display("FAIL head_pop: got %h expected 7e", w);
        else n_pass++;
        n_checks++;
`ifdef FIFO_FWFT_EN
        if ({COUNT, DOUT_VALID} !== {5'd0, 1'b0})
            $display("FAIL head_after_pop: got count=%0d valid=%b expected 0 0", COUNT, DOUT_VALID);
`else
        if ({COUNT, DOUT_VALID, DOUT} !== {5'd0, 1'b1, 8'h7E})
            $display("FAIL head_after_pop: got count=%0d valid=%b dout=%h expected 0 1 7e", COUNT, DOUT_VALID, DOUT);
`endif
        else n_pass++;
        step(1'b0, 1'b0, 8'h00, w);
        n_checks++;
        if ({DOUT_VALID, DOUT} !== {1'b0, 8'h7E})
            $display("FAIL head_hold: got valid=%b dout=%h expected 0 7e", DOUT_VALID, DOUT);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_head();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
